// File: rtl/fcs32_16_arb.sv
// Two-requester frame arbiter sharing one 16-bit CRC-32 engine; checks each frame's trailing FCS
// and returns a {source, fcs, expected, length, ok, err} result record.
module fcs32_16_arb #(
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned MIN_WORDS = 3
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic [15:0]      dat0_i,
  input  logic             sof0_i,
  input  logic             eof0_i,
  input  logic             vld0_i,
  output logic             rdy0_o,
  input  logic [15:0]      dat1_i,
  input  logic             sof1_i,
  input  logic             eof1_i,
  input  logic             vld1_i,
  output logic             rdy1_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             res_src_o,
  output logic [31:0]      res_fcs_o,
  output logic [31:0]      res_exp_o,
  output logic [LEN_W-1:0] res_len_o,
  output logic             res_ok_o,
  output logic             res_err_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, CALC, DONE} state_t;

  // CRC-32, poly 0x04C11DB7, 16 data bits per step, data MSB first.
  function automatic logic [31:0] fcs32_16(input logic [15:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic [15:0] dd;
    logic        fb;
    r  = c;
    dd = d;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = r[31] ^ dd[15];
      r  = fb ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
      dd = dd << 1;
    end
    return r;
  endfunction

  // Final FCS form: bit-reversed and complemented CRC register.
  function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
    logic [31:0] r;
    logic [31:0] cc;
    r  = '0;
    cc = c;
    for (int unsigned i = 0; i < 32; i++) begin
      r  = {r[30:0], cc[0]};
      cc = cc >> 1;
    end
    return ~r;
  endfunction

  state_t             state, state_nx;
  logic               gnt, last_src;
  logic [31:0]        crc;
  logic [LEN_W-1:0]   len;
  logic [15:0]        w1, w2;
  logic               err_flag;

  logic               req0, req1, grant_any, grant_src, src_sel;
  logic [15:0]        sel_dat;
  logic               sel_sof, sel_eof, sel_vld;
  logic [31:0]        crc_brev;
  logic               err_c;

  assign req0      = vld0_i & sof0_i;
  assign req1      = vld1_i & sof1_i;
  assign grant_any = req0 | req1;
  assign grant_src = (req0 & req1) ? ~last_src : req1;
  assign src_sel   = (state == IDLE) ? grant_src : gnt;
  assign sel_dat   = src_sel ? dat1_i : dat0_i;
  assign sel_sof   = src_sel ? sof1_i : sof0_i;
  assign sel_eof   = src_sel ? eof1_i : eof0_i;
  assign sel_vld   = src_sel ? vld1_i : vld0_i;
  assign crc_brev  = fcs32_brev(crc);
  assign err_c     = err_flag | (len < LEN_W'(MIN_WORDS));
  assign res_vld_o = (state == DONE);

  always_comb begin
    state_nx = state;
    rdy0_o   = 1'b0;
    rdy1_o   = 1'b0;
    case (state)
      IDLE: begin
        // Orphan words (valid without sof) are drained while idle.
        rdy0_o = (req0 & ~grant_src) | (vld0_i & ~sof0_i);
        rdy1_o = (req1 & grant_src) | (vld1_i & ~sof1_i);
        if (grant_any) state_nx = sel_eof ? CALC : ACTIVE;
      end
      ACTIVE: begin
        rdy0_o = ~gnt;
        rdy1_o = gnt;
        if (sel_vld & sel_eof) state_nx = CALC;
      end
      CALC:    state_nx = DONE;
      DONE:    if (res_rdy_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_src  <= 1'b1;
      crc       <= '1;
      len       <= '0;
      w1        <= '0;
      w2        <= '0;
      err_flag  <= 1'b0;
      res_src_o <= 1'b0;
      res_fcs_o <= '0;
      res_exp_o <= '0;
      res_len_o <= '0;
      res_ok_o  <= 1'b0;
      res_err_o <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant_any) begin
          gnt      <= grant_src;
          last_src <= grant_src;
          crc      <= '1;
          len      <= LEN_W'(1);
          w1       <= sel_dat;
        end
        ACTIVE: if (sel_vld) begin
          if (sel_sof) begin
            crc      <= '1;
            len      <= LEN_W'(1);
            w1       <= sel_dat;
            err_flag <= 1'b1;
          end else begin
            // A word enters the CRC only after two later words have displaced it.
            if (len >= LEN_W'(2)) crc <= fcs32_16(w2, crc);
            w2 <= w1;
            w1 <= sel_dat;
            if (len != '1) len <= len + LEN_W'(1);
          end
        end
        CALC: begin
          res_fcs_o <= crc_brev;
          res_exp_o <= {w2, w1};
          res_len_o <= len;
          res_src_o <= gnt;
          res_err_o <= err_c;
          res_ok_o  <= (crc_brev == {w2, w1}) & ~err_c;
        end
        DONE: if (res_rdy_i) err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcs32_16_arb.sv
// Bench for fcs32_16_arb: table-driven frames, hand sequences for latency/hold/reset,
// and randomized two-source traffic scored against a frame-level reference model.
module tb_fcs32_16_arb;
  localparam int LEN_W     = 12;
  localparam int MIN_WORDS = 3;
  localparam int LMAX      = (1 << LEN_W) - 1;

  logic             pclk = 1'b0;
  logic             rst;
  logic [15:0]      dat0, dat1;
  logic             sof0, eof0, vld0, sof1, eof1, vld1;
  logic             rdy0_o, rdy1_o;
  logic             res_vld_o, res_rdy;
  logic             res_src_o, res_ok_o, res_err_o;
  logic [31:0]      res_fcs_o, res_exp_o;
  logic [LEN_W-1:0] res_len_o;

  fcs32_16_arb #(.LEN_W(LEN_W), .MIN_WORDS(MIN_WORDS)) dut (
    .pclk_i(pclk), .rst_i(rst),
    .dat0_i(dat0), .sof0_i(sof0), .eof0_i(eof0), .vld0_i(vld0), .rdy0_o(rdy0_o),
    .dat1_i(dat1), .sof1_i(sof1), .eof1_i(eof1), .vld1_i(vld1), .rdy1_o(rdy1_o),
    .res_vld_o(res_vld_o), .res_rdy_i(res_rdy), .res_src_o(res_src_o),
    .res_fcs_o(res_fcs_o), .res_exp_o(res_exp_o), .res_len_o(res_len_o),
    .res_ok_o(res_ok_o), .res_err_o(res_err_o)
  );

  always #5 pclk = ~pclk;

  typedef struct { logic [15:0] d; bit sof; bit eof; } wrd_t;
  typedef struct { logic [31:0] fcs; logic [31:0] expv; logic [31:0] emask; int len; bit ok; bit err; } res_t;
  typedef struct { bit src; int np; logic [15:0] p [6]; int mode; int rs; int len; bit ok; bit err; } vec_t;

  int          checks = 0, errors = 0;
  wrd_t        tx0[$], tx1[$];
  res_t        ex0[$], ex1[$];
  logic [15:0] fr[$], pl[$];
  bit          src_log[$];
  vec_t        vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: CRC register seeded all-ones, fed fr[0..cnt-1] as one MSB-first bit stream,
  // then reported bit-reversed and complemented.
  function automatic logic [31:0] crc_of(input int cnt);
    logic [31:0] r, o;
    bit          fb;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++)
      for (int b = 15; b >= 0; b--) begin
        fb = r[31] ^ fr[i][b];
        r  = {r[30:0], 1'b0};
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    for (int b = 0; b < 32; b++) o[b] = ~r[31-b];
    return o;
  endfunction

  function automatic res_t model_result(input bit restarted);
    res_t e;
    int   n;
    n       = fr.size();
    e.fcs   = crc_of((n > 2) ? n - 2 : 0);
    e.emask = 32'h0000_FFFF;
    e.expv  = {16'h0, fr[n-1]};
    if (n >= 2) begin
      e.expv  = {fr[n-2], fr[n-1]};
      e.emask = 32'hFFFF_FFFF;
    end
    e.len = (n > LMAX) ? LMAX : n;
    e.err = restarted || (n < MIN_WORDS);
    e.ok  = !e.err && (e.fcs == e.expv);
    return e;
  endfunction

  task automatic push_word(input bit s, input logic [15:0] d, input bit sof, input bit eof);
    wrd_t w;
    w.d = d; w.sof = sof; w.eof = eof;
    if (s) tx1.push_back(w); else tx0.push_back(w);
  endtask

  task automatic push_frame(input bit s, input bit good, input bit flip, input bit restarted, output res_t e);
    logic [31:0] f;
    fr = pl;
    if (good) begin
      f = crc_of(fr.size());
      fr.push_back(f[31:16]);
      fr.push_back(f[15:0]);
    end
    if (flip) fr[0] = fr[0] ^ 16'h0001;
    for (int i = 0; i < fr.size(); i++) push_word(s, fr[i], i == 0, i == fr.size() - 1);
    e = model_result(restarted);
  endtask

  task automatic set_in(input bit s, input logic [15:0] d, input bit sof, input bit eof, input bit vld);
    if (s) begin dat1 = d; sof1 = sof; eof1 = eof; vld1 = vld; end
    else   begin dat0 = d; sof0 = sof; eof0 = eof; vld0 = vld; end
  endtask

  task automatic drive(input bit s, input int gap_pct, input int budget);
    wrd_t w;
    int   cyc = 0;
    while ((s ? tx1.size() : tx0.size()) > 0) begin
      w = s ? tx1[0] : tx0[0];
      @(negedge pclk);
      cyc++;
      if (cyc > budget) begin fail_now($sformatf("drive%0d_timeout", s)); break; end
      if (int'($urandom_range(99)) < gap_pct) begin
        set_in(s, 16'($urandom), 1'b0, 1'b0, 1'b0);
        continue;
      end
      set_in(s, w.d, w.sof, w.eof, 1'b1);
      #1;
      if (s ? rdy1_o : rdy0_o) begin
        if (s) w = tx1.pop_front(); else w = tx0.pop_front();
      end
    end
    @(negedge pclk);
    set_in(s, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp_res(input string tag, input res_t e);
    chk({tag, "_fcs"}, res_fcs_o, e.fcs);
    chk({tag, "_exp"}, res_exp_o & e.emask, e.expv & e.emask);
    chk({tag, "_len"}, res_len_o, e.len);
    chk({tag, "_ok"},  res_ok_o,  e.ok);
    chk({tag, "_err"}, res_err_o, e.err);
  endtask

  task automatic collect(input int nres, input int rdy_pct, input int budget);
    int          got = 0, cyc = 0;
    bit          held = 0;
    logic [63:0] snap_a, snap_b;
    res_t        e;
    while (got < nres) begin
      @(negedge pclk);
      cyc++;
      if (cyc > budget) begin fail_now("collect_timeout"); break; end
      res_rdy = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (res_vld_o) begin
        if (held) begin
          chk("res_stable_data", {res_fcs_o, res_exp_o}, snap_a);
          chk("res_stable_flags", 64'({res_src_o, res_len_o, res_ok_o, res_err_o}), snap_b);
        end
        if (res_rdy) begin
          held = 0;
          got++;
          src_log.push_back(res_src_o);
          if ((res_src_o ? ex1.size() : ex0.size()) == 0) fail_now("unexpected_result");
          else begin
            if (res_src_o) e = ex1.pop_front(); else e = ex0.pop_front();
            cmp_res(res_src_o ? "src1" : "src0", e);
          end
        end else begin
          held   = 1;
          snap_a = {res_fcs_o, res_exp_o};
          snap_b = 64'({res_src_o, res_len_o, res_ok_o, res_err_o});
        end
      end
    end
    @(negedge pclk);
    res_rdy = 1'b0;
  endtask

  task automatic watch_rdy1(input int budget);
    int c = 0;
    while (src_log.size() == 0 && c < budget) begin
      @(negedge pclk);
      #2;
      if (src_log.size() == 0) chk("t3_rdy1_low", rdy1_o, 1'b0);
      c++;
    end
  endtask

  task automatic reset_dut();
    @(negedge pclk);
    rst = 1'b1; res_rdy = 1'b0;
    set_in(0, 16'h0, 0, 0, 0);
    set_in(1, 16'h0, 0, 0, 0);
    tx0.delete(); tx1.delete(); ex0.delete(); ex1.delete();
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic set_vec(input int i, input bit src, input int np, input logic [15:0] a, b, c, d, f,
                         input int mode, input int rs, input int len, input bit ok, input bit err);
    vt[i].src = src; vt[i].np = np; vt[i].mode = mode; vt[i].rs = rs;
    vt[i].p[0] = a; vt[i].p[1] = b; vt[i].p[2] = c; vt[i].p[3] = d; vt[i].p[4] = f; vt[i].p[5] = 16'h0;
    vt[i].len = len; vt[i].ok = ok; vt[i].err = err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    wrd_t w;
    int   g, s, kind, np;

    // mode: 0 raw words, 1 append correct FCS, 2 append FCS then flip bit 0 of first word
    set_vec(0, 0, 2, 16'h1234, 16'hABCD, 0, 0, 0,                  1, 0, 4, 1, 0);
    set_vec(1, 0, 2, 16'h1234, 16'hABCD, 0, 0, 0,                  2, 0, 4, 0, 0);
    set_vec(2, 1, 1, 16'hBEEF, 0, 0, 0, 0,                         1, 0, 3, 1, 0);
    set_vec(3, 1, 2, 16'h0001, 16'h0002, 0, 0, 0,                  0, 0, 2, 0, 1);
    set_vec(4, 1, 3, 16'h5555, 16'hAAAA, 16'h0F0F, 0, 0,           1, 0, 5, 1, 0);
    set_vec(5, 0, 1, 16'hDEAD, 0, 0, 0, 0,                         0, 0, 1, 0, 1);
    set_vec(6, 0, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0,    1, 2, 4, 0, 1);
    set_vec(7, 0, 5, 16'hCAFE, 16'hF00D, 16'h0000, 16'hFFFF, 16'h8001, 0, 0, 5, 0, 0);

    rst = 1'b1;
    reset_dut();
    #1;
    chk("rst_rdy0", rdy0_o, 0);
    chk("rst_rdy1", rdy1_o, 0);
    chk("rst_vld", res_vld_o, 0);
    chk("rst_data", {res_fcs_o, res_exp_o}, 64'h0);
    chk("rst_flags", 64'({res_src_o, res_len_o, res_ok_o, res_err_o}), 64'h0);

    // Good src0 frame with latency check, then held result (10 cycles), release, drain.
    pl = {16'h1234, 16'hABCD};
    push_frame(0, 1, 0, 0, e);
    g = 0;
    while (tx0.size() > 0 && g < 20) begin
      @(negedge pclk);
      w = tx0[0];
      set_in(0, w.d, w.sof, w.eof, 1'b1);
      #1;
      chk("t1_rdy0", rdy0_o, 1);
      if (rdy0_o) w = tx0.pop_front();
      g++;
    end
    @(negedge pclk); set_in(0, 16'h0, 0, 0, 0); #1;
    chk("t1_calc_vld", res_vld_o, 0);
    @(negedge pclk); #1;
    chk("t1_done_vld", res_vld_o, 1);
    cmp_res("t1", e);
    chk("t1_src", res_src_o, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      res_rdy = 1'b0;
      set_in(0, 16'($urandom), 1, 0, 1);
      set_in(1, 16'($urandom), 1, 0, 1);
      #1;
      chk("t5_rdy0_low", rdy0_o, 0);
      chk("t5_rdy1_low", rdy1_o, 0);
      chk("t5_vld_held", res_vld_o, 1);
      chk("t5_data_held", {res_fcs_o, res_exp_o}, {e.fcs, e.expv});
    end
    @(negedge pclk);
    set_in(0, 16'h0, 0, 0, 0);
    set_in(1, 16'h0, 0, 0, 0);
    res_rdy = 1'b1;
    @(negedge pclk);
    res_rdy = 1'b0;
    set_in(1, 16'h7777, 0, 0, 1);
    #1;
    chk("t5_released", res_vld_o, 0);
    chk("t5_drain1", rdy1_o, 1);
    @(negedge pclk);
    set_in(1, 16'h0, 0, 0, 0);
    set_in(0, 16'h6666, 0, 1, 1);
    #1;
    chk("t5_drain0", rdy0_o, 1);
    @(negedge pclk);
    set_in(0, 16'h0, 0, 0, 0);
    #1;
    chk("t5_no_result", res_vld_o, 0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      pl.delete();
      for (int j = 0; j < vt[i].rs; j++) push_word(vt[i].src, vt[i].p[j], j == 0, 1'b0);
      for (int j = vt[i].rs; j < vt[i].np; j++) pl.push_back(vt[i].p[j]);
      push_frame(vt[i].src, vt[i].mode != 0, vt[i].mode == 2, vt[i].rs > 0, e);
      e.len = vt[i].len; e.ok = vt[i].ok; e.err = vt[i].err;
      if (vt[i].src) ex1.push_back(e); else ex0.push_back(e);
      src_log.delete();
      fork
        drive(vt[i].src, 0, 200);
        collect(1, 100, 300);
      join
      if (src_log.size() == 1) chk($sformatf("vec%0d_src", i), src_log[0], vt[i].src);
    end

    // Simultaneous sof after reset: src0 first, src1 held off until src0's result is taken.
    reset_dut();
    pl = {16'h0A0A, 16'h0B0B};
    push_frame(0, 1, 0, 0, e); ex0.push_back(e);
    pl = {16'h1C1C};
    push_frame(1, 1, 0, 0, e); ex1.push_back(e);
    src_log.delete();
    fork
      drive(0, 0, 200);
      drive(1, 0, 200);
      collect(2, 100, 300);
      watch_rdy1(200);
    join
    if (src_log.size() == 2) begin
      chk("t3_first_src", src_log[0], 0);
      chk("t3_second_src", src_log[1], 1);
    end else fail_now("t3_result_count");

    // Reset while the third word is presented: no result, data cleared, next frame clean.
    pl = {16'h1111, 16'h2222, 16'h3333};
    push_frame(0, 1, 0, 0, e);
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      w = tx0.pop_front();
      set_in(0, w.d, w.sof, w.eof, 1'b1);
    end
    @(negedge pclk);
    w = tx0.pop_front();
    set_in(0, w.d, w.sof, w.eof, 1'b1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    tx0.delete();
    set_in(0, 16'h0, 0, 0, 0);
    #1;
    chk("t6_rdy0", rdy0_o, 0);
    chk("t6_data_cleared", {res_fcs_o, res_exp_o}, 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk); #1;
      chk("t6_no_result", res_vld_o, 0);
    end
    pl = {16'h9876, 16'h5432, 16'h1357};
    push_frame(0, 1, 0, 0, e); ex0.push_back(e);
    chk("t6_model_ok", e.ok, 1);
    fork
      drive(0, 0, 200);
      collect(1, 100, 300);
    join

    // Randomized traffic on both requesters with random gaps and backpressure.
    reset_dut();
    for (int k = 0; k < 40; k++) begin
      s    = $urandom_range(1);
      kind = $urandom_range(9);
      pl.delete();
      np = (kind == 0) ? $urandom_range(4, 1) : $urandom_range(6, 1);
      for (int j = 0; j < np; j++) pl.push_back(16'($urandom));
      push_frame(s[0], kind != 0, kind == 1, 1'b0, e);
      if (s != 0) ex1.push_back(e); else ex0.push_back(e);
    end
    src_log.delete();
    fork
      drive(0, 30, 20000);
      drive(1, 30, 20000);
      collect(40, 60, 40000);
    join

    // Frame longer than the length counter: length saturates, CRC still covers every word.
    pl.delete();
    for (int j = 0; j < 4098; j++) pl.push_back(16'($urandom));
    push_frame(0, 1, 0, 0, e); ex0.push_back(e);
    chk("sat_model_len", e.len, LMAX);
    fork
      drive(0, 0, 6000);
      collect(1, 100, 6000);
    join

    chk("ex0_drained", ex0.size(), 0);
    chk("ex1_drained", ex1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
